// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if: data-side SRAM-like req/addr_ok/data_ok bus
interface data_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder: word-addressed data memory answering in order after a fixed latency
module data_sram_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int QUEUE_DEPTH = 4,
  parameter int DATA_LAT    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  data_sram_responder_if.slave         data_sram,
  input  logic                         stall_in,
  output logic [$clog2(QUEUE_DEPTH):0] outstanding
);
  localparam int PW = QUEUE_DEPTH > 1 ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = DATA_LAT > 1 ? $clog2(DATA_LAT) : 1;
  localparam int OW = $clog2(QUEUE_DEPTH) + 1;
  logic [31:0]           mem    [2**ADDR_WIDTH];
  logic [31:0]           q_data [QUEUE_DEPTH];
  logic                  q_wr   [QUEUE_DEPTH];
  logic                  q_vld  [QUEUE_DEPTH];
  logic [CW-1:0]         q_cnt  [QUEUE_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  acc, pop;
  logic                  unused_bits;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(QUEUE_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign idx               = data_sram.addr[ADDR_WIDTH+1:2];
  assign unused_bits       = ^{data_sram.size, data_sram.addr[31:ADDR_WIDTH+2], data_sram.addr[1:0]};
  assign data_sram.addr_ok = !reset && !stall_in && outstanding < OW'(QUEUE_DEPTH);
  assign acc               = data_sram.req && data_sram.addr_ok;
  assign pop               = q_vld[rd_ptr] && q_cnt[rd_ptr] == '0;
  always_ff @(posedge clk)
    if (acc && data_sram.wr)
      for (int i = 0; i < 4; i++)
        if (data_sram.wstrb[i]) mem[idx][8*i +: 8] <= data_sram.wdata[8*i +: 8];
  // reads capture the word now, so later writes cannot leak into a queued response
  always_ff @(posedge clk)
    if (reset) begin
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      outstanding       <= '0;
      data_sram.data_ok <= 1'b0;
      data_sram.rdata   <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_vld[i] <= 1'b0;
        q_cnt[i] <= '0;
      end
    end else begin
      rd_ptr            <= pop ? nxt(rd_ptr) : rd_ptr;
      wr_ptr            <= acc ? nxt(wr_ptr) : wr_ptr;
      outstanding       <= outstanding + OW'(acc) - OW'(pop);
      data_sram.data_ok <= pop;
      data_sram.rdata   <= pop && !q_wr[rd_ptr] ? q_data[rd_ptr] : '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (q_vld[i] && q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - 1'b1;
        if (pop && PW'(i) == rd_ptr) q_vld[i] <= 1'b0;
        if (acc && PW'(i) == wr_ptr) begin
          q_vld[i]  <= 1'b1;
          q_cnt[i]  <= CW'(DATA_LAT - 1);
          q_wr[i]   <= data_sram.wr;
          q_data[i] <= data_sram.wr ? '0 : mem[idx];
        end
      end
    end
endmodule
